// File: rtl/amplitude_ramp_generator.sv
// Slews a registered per-channel amplitude toward a live target in prescaled fixed steps, with soft start/stop.
// Latency: state follows enable on the next edge; first step lands prescaler+1 edges after entering RAMP/STOP.
// Backpressure: none, free-running; optional ramp_count output under `define AMP_RAMP_COUNT_EN.
module amplitude_ramp_generator #(
    parameter int CFG_DATA_WIDTH  = 16,
    parameter int PRESCALER_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic                       enable,
    input  logic [CFG_DATA_WIDTH-1:0]  target_amplitude,
    input  logic [CFG_DATA_WIDTH-1:0]  step_size,
    input  logic [PRESCALER_WIDTH-1:0] prescaler,
    output logic [CFG_DATA_WIDTH-1:0]  amplitude_out,
    output logic                       ramping,
    output logic                       at_target,
    output logic                       stopped
`ifdef AMP_RAMP_COUNT_EN
    ,
    output logic [15:0]                ramp_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_HOLD = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [PRESCALER_WIDTH-1:0] cnt_q, cnt_d;
    logic [CFG_DATA_WIDTH-1:0]  amp_q, amp_d;
    logic [CFG_DATA_WIDTH-1:0]  goal;
    logic [CFG_DATA_WIDTH-1:0]  stepped;
    logic [CFG_DATA_WIDTH-1:0]  down_gap;
    logic [CFG_DATA_WIDTH:0]    up_sum;
    logic                       moving;
    logic                       tick;

    assign moving = (state_q == ST_RAMP) || (state_q == ST_STOP);
    assign tick   = moving && (cnt_q >= prescaler);
    assign goal   = (state_q == ST_STOP) ? '0 : target_amplitude;

    // One extra bit on the way up so amp+step cannot wrap past full scale.
    always_comb begin
        up_sum   = {1'b0, amp_q} + {1'b0, step_size};
        down_gap = amp_q - goal;
        stepped  = amp_q;
        if (step_size == '0) begin
            stepped = goal;
        end else if (amp_q < goal) begin
            stepped = (up_sum > {1'b0, goal}) ? goal : up_sum[CFG_DATA_WIDTH-1:0];
        end else if (amp_q > goal) begin
            stepped = (down_gap <= step_size) ? goal : (amp_q - step_size);
        end
    end

    always_comb begin
        state_d = state_q;
        amp_d   = amp_q;
        case (state_q)
            ST_IDLE: begin
                amp_d = '0;
                if (enable) state_d = ST_RAMP;
            end
            ST_RAMP: begin
                if (!enable)                          state_d = ST_STOP;
                else if (amp_q == target_amplitude)   state_d = ST_HOLD;
                else if (tick)                        amp_d   = stepped;
            end
            ST_HOLD: begin
                if (!enable)                          state_d = ST_STOP;
                else if (target_amplitude != amp_q)   state_d = ST_RAMP;
            end
            ST_STOP: begin
                if (enable)                           state_d = ST_RAMP;
                else if (amp_q == '0)                 state_d = ST_IDLE;
                else if (tick)                        amp_d   = stepped;
            end
            default: begin
                state_d = ST_IDLE;
                amp_d   = '0;
            end
        endcase
    end

    // A state change restarts the prescale period so each new leg gets a full first interval.
    always_comb begin
        cnt_d = '0;
        if (moving && (state_d == state_q) && !tick) begin
            cnt_d = cnt_q + {{(PRESCALER_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            amp_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            amp_q   <= amp_d;
        end
    end

    assign amplitude_out = amp_q;
    assign ramping       = moving;
    assign at_target     = (state_q == ST_HOLD);
    assign stopped       = (state_q == ST_IDLE);

`ifdef AMP_RAMP_COUNT_EN
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            ramp_count <= '0;
        end else if ((state_q == ST_RAMP) && (state_d == ST_HOLD)) begin
            ramp_count <= ramp_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_amplitude_ramp_generator.sv
// Bench for amplitude_ramp_generator: directed scenarios with literal expectations plus randomized
// stimulus, all checked every cycle against an arithmetic reference model.
module tb_amplitude_ramp_generator;

    localparam int W  = 16;
    localparam int PW = 16;

    localparam int M_IDLE = 0;
    localparam int M_RAMP = 1;
    localparam int M_HOLD = 2;
    localparam int M_STOP = 3;

    logic          clk = 1'b0;
    logic          aresetn;
    logic          enable;
    logic [W-1:0]  target_amplitude;
    logic [W-1:0]  step_size;
    logic [PW-1:0] prescaler;
    logic [W-1:0]  amplitude_out;
    logic          ramping;
    logic          at_target;
    logic          stopped;
`ifdef AMP_RAMP_COUNT_EN
    logic [15:0]   ramp_count;
`endif

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    int m_mode = M_IDLE;
    int m_amp  = 0;
    int m_cnt  = 0;
    int m_rcnt = 0;

    amplitude_ramp_generator #(.CFG_DATA_WIDTH(W), .PRESCALER_WIDTH(PW)) dut (
        .clk              (clk),
        .aresetn          (aresetn),
        .enable           (enable),
        .target_amplitude (target_amplitude),
        .step_size        (step_size),
        .prescaler        (prescaler),
        .amplitude_out    (amplitude_out),
        .ramping          (ramping),
        .at_target        (at_target),
        .stopped          (stopped)
`ifdef AMP_RAMP_COUNT_EN
        ,
        .ramp_count       (ramp_count)
`endif
    );

    always #4 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int step_toward(input int a, input int g, input int s);
        if (s == 0) return g;
        if (a < g)  return (a + s > g) ? g : a + s;
        if (a > g)  return (a - g <= s) ? g : a - s;
        return a;
    endfunction

    // Reference model: plain integer arithmetic on the behavioural rules.
    always @(posedge clk) begin : model
        int  nmode;
        int  goal;
        bit  tick;
        if (!aresetn) begin
            m_mode = M_IDLE;
            m_amp  = 0;
            m_cnt  = 0;
            m_rcnt = 0;
        end else begin
            tick  = (m_mode == M_RAMP || m_mode == M_STOP) && (m_cnt >= int'(prescaler));
            goal  = (m_mode == M_STOP) ? 0 : int'(target_amplitude);
            nmode = m_mode;
            if (m_mode == M_IDLE) begin
                if (enable) nmode = M_RAMP;
            end else if (m_mode == M_HOLD) begin
                if (!enable) nmode = M_STOP;
                else if (int'(target_amplitude) != m_amp) nmode = M_RAMP;
            end else if (m_mode == M_RAMP) begin
                if (!enable) nmode = M_STOP;
                else if (m_amp == int'(target_amplitude)) nmode = M_HOLD;
            end else begin
                if (enable) nmode = M_RAMP;
                else if (m_amp == 0) nmode = M_IDLE;
            end
            if (nmode == m_mode && tick) m_amp = step_toward(m_amp, goal, int'(step_size));
            if (nmode == m_mode && (m_mode == M_RAMP || m_mode == M_STOP) && !tick) m_cnt = m_cnt + 1;
            else m_cnt = 0;
            if (m_mode == M_RAMP && nmode == M_HOLD) m_rcnt = (m_rcnt + 1) % 65536;
            m_mode = nmode;
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("model_amp",       int'(amplitude_out), m_amp);
            chk("model_ramping",   int'(ramping),   int'(m_mode == M_RAMP || m_mode == M_STOP));
            chk("model_at_target", int'(at_target), int'(m_mode == M_HOLD));
            chk("model_stopped",   int'(stopped),   int'(m_mode == M_IDLE));
`ifdef AMP_RAMP_COUNT_EN
            chk("model_ramp_count", int'(ramp_count), m_rcnt);
`endif
        end
    end

    task automatic wait_amp(input int v);
        int  n = 0;
        bit  ok = 1'b0;
        while (!ok && n < 3000) begin
            @(negedge clk);
            n++;
            ok = (int'(amplitude_out) == v);
        end
        chk($sformatf("wait_amp_%0d", v), int'(ok), 1);
    endtask

    task automatic wait_hold();
        int  n = 0;
        bit  ok = 1'b0;
        while (!ok && n < 3000) begin
            @(negedge clk);
            n++;
            ok = at_target;
        end
        chk("wait_hold", int'(ok), 1);
    endtask

    task automatic wait_idle();
        int  n = 0;
        bit  ok = 1'b0;
        while (!ok && n < 3000) begin
            @(negedge clk);
            n++;
            ok = stopped;
        end
        chk("wait_idle", int'(ok), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        aresetn = 1'b0; enable = 1'b1; target_amplitude = 16'd1000;
        step_size = 16'd10; prescaler = '0;

        // Reset held with enable high
        @(posedge clk);
        run_cmp = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_amp", int'(amplitude_out), 0);
            chk("rst_stopped", int'(stopped), 1);
            chk("rst_ramping", int'(ramping), 0);
            chk("rst_at_target", int'(at_target), 0);
        end
        enable = 1'b0;
        @(posedge clk); #1;
        aresetn = 1'b1;

        // Ramp up every cycle
        @(posedge clk); #1;
        target_amplitude = 16'd100; step_size = 16'd10; prescaler = '0; enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("up_entry_ramping", int'(ramping), 1);
        chk("up_entry_amp", int'(amplitude_out), 0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("up_amp_%0d", k), int'(amplitude_out), 10 * k);
        end
        @(negedge clk);
        chk("up_at_target", int'(at_target), 1);

        // Clamped step with prescaler 3
        enable = 1'b0;
        wait_idle();
        target_amplitude = 16'd25; step_size = 16'd10; prescaler = 16'd3; enable = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("pre_amp_%0d", k), int'(amplitude_out), (10 * (k / 4) > 25) ? 25 : 10 * (k / 4));
        end
        @(negedge clk);
        chk("pre_at_target", int'(at_target), 1);

        // Range edges
        target_amplitude = 16'd65530; step_size = 16'd0; prescaler = '0;
        wait_amp(65530);
        wait_hold();
        target_amplitude = 16'd65535; step_size = 16'd1000;
        @(negedge clk);
        @(negedge clk);
        chk("edge_top", int'(amplitude_out), 65535);
        wait_hold();
        target_amplitude = 16'd0; step_size = 16'd40000;
        @(negedge clk);
        @(negedge clk);
        chk("edge_down1", int'(amplitude_out), 25535);
        @(negedge clk);
        chk("edge_down2", int'(amplitude_out), 0);
        wait_hold();
        target_amplitude = 16'd500; step_size = 16'd0;
        @(negedge clk);
        @(negedge clk);
        chk("edge_jump", int'(amplitude_out), 500);
        wait_hold();

        // Soft stop from 60
        target_amplitude = 16'd100; step_size = 16'd10;
        enable = 1'b0;
        wait_idle();
        enable = 1'b1;
        wait_amp(60);
        enable = 1'b0;
        @(negedge clk);
        chk("stop_hold_amp", int'(amplitude_out), 60);
        chk("stop_ramping", int'(ramping), 1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("stop_amp_%0d", k), int'(amplitude_out), 60 - 10 * k);
        end
        @(negedge clk);
        chk("stop_stopped", int'(stopped), 1);

        // Soft stop interrupted at 30
        enable = 1'b1;
        wait_amp(60);
        enable = 1'b0;
        wait_amp(30);
        enable = 1'b1;
        @(negedge clk);
        chk("resume_amp", int'(amplitude_out), 30);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("resume_amp_%0d", k), int'(amplitude_out), 30 + 10 * k);
        end
        @(negedge clk);
        chk("resume_at_target", int'(at_target), 1);

        // Reset mid-ramp
        enable = 1'b0;
        wait_idle();
        enable = 1'b1;
        wait_amp(40);
        aresetn = 1'b0;
        @(negedge clk);
        chk("midrst_amp", int'(amplitude_out), 0);
        chk("midrst_stopped", int'(stopped), 1);
        aresetn = 1'b1; enable = 1'b0;
        @(negedge clk);

        // Three ramps to HOLD after reset
        target_amplitude = 16'd50; enable = 1'b1;
        wait_hold();
        target_amplitude = 16'd20;
        wait_amp(20);
        wait_hold();
        target_amplitude = 16'd70;
        wait_amp(70);
        wait_hold();
`ifdef AMP_RAMP_COUNT_EN
        chk("ramp_count_3", int'(ramp_count), 3);
`endif

        // Randomized stimulus
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            aresetn = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 19) == 0) enable = ~enable;
            if ($urandom_range(0, 11) == 0) target_amplitude = W'($urandom_range(0, 300));
            if ($urandom_range(0, 59) == 0) target_amplitude = W'($urandom_range(0, 65535));
            if ($urandom_range(0, 11) == 0) step_size = W'($urandom_range(0, 60));
            if ($urandom_range(0, 59) == 0) step_size = W'($urandom_range(0, 65535));
            if ($urandom_range(0, 15) == 0) prescaler = PW'($urandom_range(0, 4));
        end
        aresetn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        run_cmp = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
